// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial add/subtract controller. One full-adder cell is reused once
//   per cycle, LSB first. The carry between bits is held in a flop. A
//   WIDTH-bit result therefore takes WIDTH RUN cycles plus one DONE cycle.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request pulse, sampled only in IDLE
//   sub    0 = A+B, 1 = A-B, sampled with start
//   A, B   operands, sampled with start
//   busy   high during RUN and DONE
//   done   one-cycle pulse in DONE when the result is valid
//   Sum    result, modulo 2^WIDTH; holds until the next completion
//   Cout   final carry out; for subtract, 1 means no borrow
//   Ovf    signed overflow
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;

    // Shared one-bit full-adder cell
    always_comb begin
        fa_s = ra[0] ^ rb[0] ^ carry;
        fa_c = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
    end

    assign last_bit = (cnt == LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath. The result registers are loaded on the final RUN cycle,
    // i.e. on the transition into DONE. During that cycle the carry flop
    // still holds the carry into the MSB cell, so signed overflow is
    // formed from it and the cell's carry out directly. This avoids
    // keeping a separate copy of the MSB carry-in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= A;
                        rb    <= B ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    res   <= {fa_s, res[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        Sum  <= {fa_s, res[WIDTH-1:1]};
                        Cout <= fa_c;
                        Ovf  <= carry ^ fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl (WIDTH = 8).
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int unsigned checks = 0;
    int unsigned errors = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .Sum   (sum),
        .Cout  (cout),
        .Ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it for W+4 cycles after the start edge.
    // Cycle c is the cycle following edge k+c-1 (edge k = accepting edge).
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic sv, input logic [7:0] es, input logic ec,
                          input logic eo, input bit repulse, input logic [7:0] prev_sum);
        int busy_n  = 0;
        int done_n  = 0;
        int done_at = 0;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        sub   = sv;
        @(posedge clk);
        for (int c = 1; c <= int'(W) + 4; c++) begin
            @(negedge clk);
            // Operands change after acceptance and must not matter
            start = 1'b0;
            a     = 8'hAA;
            b     = 8'h5A;
            sub   = ~sv;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = c;
            end
            if (c == int'(W)) check({tag, " sum_hidden"}, sum, prev_sum);
            if (repulse && (c == 3 || c == int'(W) + 1)) begin
                start = 1'b1;
                a     = 8'h55;
                b     = 8'h55;
            end
        end
        check({tag, " busy_cycles"}, busy_n, W + 1);
        check({tag, " done_count"}, done_n, 1);
        check({tag, " done_cycle"}, done_at, W + 1);
        check({tag, " busy_after"}, busy, 1'b0);
        check({tag, " sum"}, sum, es);
        check({tag, " cout"}, cout, ec);
        check({tag, " ovf"}, ovf, eo);
    endtask

    initial begin
        int done_n;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst sum", sum, 8'h00);
        check("rst cout", cout, 1'b0);
        check("rst ovf", ovf, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("add_ovf",   8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 8'h00);
        run_op("add_carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h81);
        run_op("sub_borrow",8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 8'h00);
        run_op("sub_ovf",   8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 8'hF0);
        run_op("held",      8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 8'h7F);

        // Reset in RUN cycle 4
        @(negedge clk);
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        sub   = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst busy", busy, 1'b0);
        check("mid_rst done", done, 1'b0);
        check("mid_rst sum", sum, 8'h00);
        check("mid_rst cout", cout, 1'b0);
        check("mid_rst ovf", ovf, 1'b0);
        done_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        rst = 1'b0;
        for (int i = 0; i < int'(W) + 4; i++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("mid_rst no_done", done_n, 0);
        check("mid_rst idle", busy, 1'b0);

        run_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
